// File: rtl/sort_ctrl_fsm.sv
// Control FSM for the in-place exchange-sort engine.
// Drives datapath strobes from the current state and counts swaps.
module sort_ctrl_fsm #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             AgtB,
    input  logic             zi,
    input  logic             zj,
    output logic             EA,
    output logic             EB,
    output logic             Li,
    output logic             Ei,
    output logic             Lj,
    output logic             Ej,
    output logic             Csel,
    output logic             WE,
    output logic             Bout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] swap_cnt
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD_A   = 4'd1,
        S_LOAD_B   = 4'd2,
        S_CMP      = 4'd3,
        S_WR_J     = 4'd4,
        S_WR_I     = 4'd5,
        S_RELOAD_A = 4'd6,
        S_NEXT_J   = 4'd7,
        S_NEXT_I   = 4'd8,
        S_DONE     = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        EA      = 1'b0;
        EB      = 1'b0;
        Li      = 1'b0;
        Ei      = 1'b0;
        Lj      = 1'b0;
        Ej      = 1'b0;
        Csel    = 1'b0;
        WE      = 1'b0;
        Bout    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    Li      = 1'b1;
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                busy    = 1'b1;
                EA      = 1'b1;
                Lj      = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                busy    = 1'b1;
                Csel    = 1'b1;
                EB      = 1'b1;
                state_d = S_CMP;
            end
            S_CMP: begin
                busy    = 1'b1;
                state_d = AgtB ? S_WR_J : S_NEXT_J;
            end
            S_WR_J: begin
                busy    = 1'b1;
                Csel    = 1'b1;
                WE      = 1'b1;
                state_d = S_WR_I;
            end
            S_WR_I: begin
                busy    = 1'b1;
                WE      = 1'b1;
                Bout    = 1'b1;
                state_d = S_RELOAD_A;
                // saturate rather than wrap
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELOAD_A: begin
                busy    = 1'b1;
                EA      = 1'b1;
                state_d = S_NEXT_J;
            end
            S_NEXT_J: begin
                busy = 1'b1;
                if (zj) begin
                    state_d = S_NEXT_I;
                end else begin
                    Ej      = 1'b1;
                    state_d = S_LOAD_B;
                end
            end
            S_NEXT_I: begin
                busy = 1'b1;
                if (zi) begin
                    state_d = S_DONE;
                end else begin
                    Ei      = 1'b1;
                    state_d = S_LOAD_A;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // keep the datapath quiet while reset is held
        if (rst) begin
            EA   = 1'b0;
            EB   = 1'b0;
            Li   = 1'b0;
            Ei   = 1'b0;
            Lj   = 1'b0;
            Ej   = 1'b0;
            Csel = 1'b0;
            WE   = 1'b0;
            Bout = 1'b0;
            busy = 1'b0;
            done = 1'b0;
        end
    end

    assign swap_cnt = rst ? '0 : cnt_q;

endmodule

// File: doc/sort_ctrl_fsm.md
Name: sort_ctrl_fsm

Overview:
- Control unit for the in-place exchange-sort engine.
- Sits directly beside the sort datapath:
  - drives every datapath control strobe (EA, EB, Li, Ei, Lj, Ej, Csel, WE, Bout);
  - consumes the datapath flags (AgtB, zi, zj).
- Provides a start/done handshake to the system and reports a swap count for debug/performance.
- Sorts the K-entry data memory in ascending order.

Parameters:
CNT_W, 8, width of the swap counter output swap_cnt (saturating).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a sort; level-sampled in IDLE.
AgtB  input  1  datapath flag: A_reg > B_reg.
zi  input  1  datapath flag: i_cnt == K-2.
zj  input  1  datapath flag: j_cnt == K-1.
EA  output  1  load A_reg from Dout.
EB  output  1  load B_reg from Dout.
Li  output  1  clear i_cnt.
Ei  output  1  increment i_cnt.
Lj  output  1  load j_cnt with i_cnt+1.
Ej  output  1  increment j_cnt.
Csel  output  1  address select: 0 = i_cnt, 1 = j_cnt.
WE  output  1  memory write enable.
Bout  output  1  write-data select: 0 = A_reg, 1 = B_reg.
busy  output  1  high in every state except IDLE and DONE.
done  output  1  high while in DONE.
swap_cnt  output  CNT_W  swaps performed in the current/last sort.

Behaviour:
Clock and reset:
- One clock, clk.
- rst is synchronous and active-high: on a rising edge with rst=1, the state goes to IDLE and swap_cnt goes to 0.
- Reset mid-sort aborts immediately; memory contents are left as-is.

Memory model:
- Combinational read: Dout is valid in the same cycle as Addr.
- Write occurs on the clk edge while WE=1.

Output decoding:
- All strobes are decoded from the current state. Li is additionally qualified by start.
- Any strobe not listed for a state is 0.
- During and after reset every output is 0, except swap_cnt, which is also 0.

States and transitions:
- IDLE: if start=1, assert Li, clear swap_cnt, go to LOAD_A. Otherwise stay.
- LOAD_A: Csel=0, EA=1, Lj=1. A = M[i], j = i+1. Go to LOAD_B.
- LOAD_B: Csel=1, EB=1. B = M[j]. Go to CMP.
- CMP: no strobes. If AgtB go to WR_J, else go to NEXT_J.
- WR_J: Csel=1, Bout=0, WE=1. M[j] = A. Go to WR_I.
- WR_I: Csel=0, Bout=1, WE=1. M[i] = B. Increment swap_cnt, saturating at 2^CNT_W-1. Go to RELOAD_A.
- RELOAD_A: Csel=0, EA=1. A = new M[i]. Go to NEXT_J.
- NEXT_J: if zj go to NEXT_I; else Ej=1 and go to LOAD_B.
- NEXT_I: if zi go to DONE; else Ei=1 and go to LOAD_A.
- DONE: done=1, busy=0. Stay while start=1; go to IDLE when start=0. A new sort therefore requires start to drop and rise again.

Handshake and counter rules:
- start is ignored in every state except IDLE.
- swap_cnt holds its value in IDLE and DONE until the next accepted start.

Timing (K=8; edge 0 is the edge that samples start in IDLE):
- Each outer pass costs LOAD_A + NEXT_I = 2 cycles.
- Each compare costs 3 cycles: LOAD_B, CMP, NEXT_J.
- Each swap adds 3 cycles: WR_J, WR_I, RELOAD_A.
- Total: 7*2 + 28*3 + 3*swaps = 98 + 3*swaps cycles. done is first high after edge 98 + 3*swaps.

Illegal state encodings:
- Any illegal encoding returns to IDLE on the next edge with all strobes 0.

Test Plan:
1. Memory [1,2,3,4,5,6,7,8], start pulsed high -> Li high on the accept edge only. done first high after edge 98. swap_cnt=0. Memory unchanged.
2. Memory [8,7,6,5,4,3,2,1] -> done after edge 182. swap_cnt=28. Memory [1..8]. WE is never high outside WR_J/WR_I.
3. Memory [5,3,8,1,7,2,6,4] -> final memory [1,2,3,4,5,6,7,8]. done=1 and busy=0 in DONE. Bench scoreboard matches the cycle count 98 + 3*swap_cnt.
4. Hold start=1 through completion -> FSM stays in DONE. Drop start -> IDLE. Re-raise start -> new sort begins and swap_cnt clears to 0.
5. Assert rst for 1 cycle at cycle 40 of a reverse-order sort -> next state is IDLE, all strobes 0, swap_cnt=0. Restart completes with a correctly sorted memory.
6. Duplicates [4,4,2,2,9,9,0,0] -> no swap when A==B (AgtB=0). Final memory [0,0,2,2,4,4,9,9].
